// File: rtl/inst_legal_chk.sv
// Registered RISC-V instruction legality check: classifies each accepted word,
// emits trap cause/tval/epc one cycle later, and tracks the first illegal word.
module inst_legal_chk #(
  parameter int XLEN     = 64,
  parameter int EN_M     = 1,
  parameter int EN_ZICSR = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             halt_on_illegal,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_trap,
  output logic [3:0]       out_cause,
  output logic             out_mret,
  output logic [XLEN-1:0]  out_tval,
  output logic [XLEN-1:0]  out_epc,
  output logic             first_valid,
  output logic [31:0]      first_inst,
  output logic [XLEN-1:0]  first_pc,
  output logic [CNT_W-1:0] ill_cnt,
  output logic             halted
);

  localparam logic [31:0]      ECALL      = 32'h0000_0073;
  localparam logic [31:0]      EBREAK     = 32'h0010_0073;
  localparam logic [31:0]      MRET       = 32'h3020_0073;
  localparam logic [3:0]       CAUSE_NONE = 4'd0;
  localparam logic [3:0]       CAUSE_ILL  = 4'd2;
  localparam logic [3:0]       CAUSE_BRK  = 4'd3;
  localparam logic [3:0]       CAUSE_ECM  = 4'd11;
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam bit               RV64       = (XLEN == 64);
  localparam bit               HAS_M      = (EN_M != 0);
  localparam bit               HAS_CSR    = (EN_ZICSR != 0);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t     state_r, state_nxt_s;
  logic       fresh_r, cap_ok_r;
  logic       legal_s, illegal_s, mret_s, accept_s, capture_s;
  logic [3:0] cause_s;

  function automatic logic is_legal(input logic [31:0] inst);
    logic [2:0] f3;
    logic [6:0] f7;
    logic       ok;
    f3 = inst[14:12];
    f7 = inst[31:25];
    ok = 1'b0;
    if (inst[1:0] != 2'b11) begin
      ok = 1'b0;
    end else begin
      case (inst[6:0])
        7'b0110111, 7'b0010111, 7'b1101111: ok = 1'b1;
        7'b1100111, 7'b0001111: ok = (f3 == 3'd0);
        7'b1100011: ok = (f3 != 3'd2) && (f3 != 3'd3);
        7'b0000011: ok = (f3 != 3'd7) && ((f3 != 3'd3 && f3 != 3'd6) || RV64);
        7'b0100011: ok = (f3 <= 3'd2) || (RV64 && f3 == 3'd3);
        7'b0010011: begin
          case (f3)
            3'd1:    ok = RV64 ? (f7[6:1] == 6'h00) : (f7 == 7'h00);
            3'd5:    ok = RV64 ? (f7[6:1] == 6'h00 || f7[6:1] == 6'h10)
                                : (f7 == 7'h00 || f7 == 7'h20);
            default: ok = 1'b1;
          endcase
        end
        7'b0110011: ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) ||
                         (f7 == 7'h01 && HAS_M);
        7'b0011011: ok = RV64 && ((f3 == 3'd0) || (f3 == 3'd1 && f7 == 7'h00) ||
                                  (f3 == 3'd5 && (f7 == 7'h00 || f7 == 7'h20)));
        7'b0111011: ok = RV64 && ((f7 == 7'h00 && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd5)) ||
                                  (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) ||
                                  (f7 == 7'h01 && HAS_M && (f3 == 3'd0 || f3[2])));
        7'b1110011: begin
          if (f3 == 3'd0) begin
            ok = (inst == ECALL) || (inst == EBREAK) || (inst == MRET);
          end else if (f3 == 3'd4) begin
            ok = 1'b0;
          end else begin
            ok = HAS_CSR;
          end
        end
        default: ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  // Classify the offered word and decide acceptance
  always_comb begin
    legal_s   = is_legal(in_inst);
    illegal_s = !legal_s;
    mret_s    = legal_s && (in_inst == MRET);
    if (illegal_s) begin
      cause_s = CAUSE_ILL;
    end else if (in_inst == EBREAK) begin
      cause_s = CAUSE_BRK;
    end else if (in_inst == ECALL) begin
      cause_s = CAUSE_ECM;
    end else begin
      cause_s = CAUSE_NONE;
    end
  end

  assign in_ready  = !rst && (state_r == RUN) && (!out_valid || out_ready);
  assign accept_s  = in_valid && in_ready;
  // Capture only on the first cycle of an illegal beat that was not accepted under clr
  assign capture_s = out_valid && fresh_r && cap_ok_r && (out_cause == CAUSE_ILL) && !first_valid;
  assign halted    = (state_r == HALT);

  // Output pipeline register; holds while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_trap  <= 1'b0;
      out_cause <= CAUSE_NONE;
      out_mret  <= 1'b0;
      out_tval  <= '0;
      out_epc   <= '0;
      fresh_r   <= 1'b0;
      cap_ok_r  <= 1'b0;
    end else if (accept_s) begin
      out_valid <= 1'b1;
      out_trap  <= (cause_s != CAUSE_NONE);
      out_cause <= cause_s;
      out_mret  <= mret_s;
      out_tval  <= illegal_s ? XLEN'(in_inst) : '0;
      out_epc   <= in_pc;
      fresh_r   <= 1'b1;
      cap_ok_r  <= !clr;
    end else begin
      fresh_r <= 1'b0;
      if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Sticky first-illegal capture and saturating illegal counter
  always_ff @(posedge clk) begin
    if (rst) begin
      first_valid <= 1'b0;
      first_inst  <= 32'h0;
      first_pc    <= '0;
      ill_cnt     <= '0;
    end else if (clr) begin
      first_valid <= 1'b0;
      ill_cnt     <= '0;
    end else begin
      if (capture_s) begin
        first_valid <= 1'b1;
        first_inst  <= out_tval[31:0];
        first_pc    <= out_epc;
      end
      if (accept_s && illegal_s && (ill_cnt != CNT_MAX)) begin
        ill_cnt <= ill_cnt + CNT_W'(1);
      end
    end
  end

  // Run/halt state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Run/halt next state; clr always wins over a halting accept
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      RUN: begin
        if (!clr && accept_s && illegal_s && halt_on_illegal) begin
          state_nxt_s = HALT;
        end else begin
          state_nxt_s = RUN;
        end
      end
      HALT: begin
        if (clr) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = HALT;
        end
      end
      default: state_nxt_s = RUN;
    endcase
  end

endmodule
